// File: rtl/crt_sync_monitor.sv
// Receive-side monitor for crttest-style video: measures line/frame geometry,
// locks to the expected timing, regenerates x/y/de and signs each locked frame.
module crt_sync_monitor #(
  parameter int H_TOTAL  = 309,
  parameter int V_TOTAL  = 262,
  parameter int H_BP     = 23,
  parameter int V_BP     = 4,
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        de,
  output logic [2:0]  pix,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic [15:0] frame_sum,
  output logic        sum_valid,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0] H_BP_C    = 10'(H_BP);
  localparam logic [9:0] V_BP_C    = 10'(V_BP);
  localparam logic [9:0] H_END_C   = 10'(H_BP + H_ACTIVE);
  localparam logic [9:0] V_END_C   = 10'(V_BP + V_ACTIVE);

  function automatic logic [15:0] sig_step(input logic [15:0] a, input logic [2:0] c);
    return {a[14:0], a[15]} ^ {13'd0, c};
  endfunction

  logic        hs_r, hs_prev_r, vs_r, vs_prev_r;
  logic [2:0]  rgb_r;
  logic [9:0]  hcnt_r, vcnt_r;
  logic        vpend_r;
  logic [15:0] acc_r;
  state_t      state_r, state_nxt_s;

  logic [8:0]  x_r, y_r;
  logic        de_r, frame_start_r, locked_r, sum_valid_r;
  logic [2:0]  pix_r;
  logic [9:0]  line_len_r, frame_lines_r;
  logic [15:0] frame_sum_r;
  logic [7:0]  err_cnt_r;

  logic        hfall_s, vfall_s, frame_bnd_s, timeout_s;
  logic        line_err_s, frame_err_s, geo_err_s;
  logic [9:0]  hcnt_inc_s, vcnt_inc_s, hcnt_nxt_s, vcnt_nxt_s;
  logic        vpend_nxt_s;
  logic        in_h_s, in_v_s, de_nxt_s, frame_start_nxt_s, err_inc_s, sum_pub_s;
  logic [8:0]  x_nxt_s, y_nxt_s;
  logic [2:0]  pix_nxt_s;
  logic [15:0] acc_base_s, acc_nxt_s;

  // Edge detection and counter arithmetic; the new line/frame length is the
  // saturated count including the boundary tick itself.
  always_comb begin
    hfall_s     = hs_prev_r & ~hs_r;
    vfall_s     = vs_prev_r & ~vs_r;
    frame_bnd_s = hfall_s & (vpend_r | vfall_s);
    timeout_s   = (hcnt_r == CNT_MAX);
    hcnt_inc_s  = (hcnt_r == CNT_MAX) ? CNT_MAX : hcnt_r + 10'd1;
    vcnt_inc_s  = (vcnt_r == CNT_MAX) ? CNT_MAX : vcnt_r + 10'd1;
    hcnt_nxt_s  = hfall_s ? 10'd0 : hcnt_inc_s;
    if (frame_bnd_s) begin
      vcnt_nxt_s = 10'd0;
    end else if (hfall_s) begin
      vcnt_nxt_s = vcnt_inc_s;
    end else begin
      vcnt_nxt_s = vcnt_r;
    end
    if (frame_bnd_s) begin
      vpend_nxt_s = 1'b0;
    end else if (vfall_s) begin
      vpend_nxt_s = 1'b1;
    end else begin
      vpend_nxt_s = vpend_r;
    end
    line_err_s  = hfall_s & (hcnt_inc_s != H_TOTAL_C);
    frame_err_s = frame_bnd_s & (vcnt_inc_s != V_TOTAL_C);
    geo_err_s   = line_err_s | frame_err_s | timeout_s;
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SEARCH;
    end else if (pix_en) begin
      state_r <= state_nxt_s;
    end
  end

  // Lock FSM next state: geometry errors only matter once a boundary was seen.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEARCH: begin
        if (frame_bnd_s) state_nxt_s = CHECK;
        else             state_nxt_s = SEARCH;
      end
      CHECK: begin
        if (geo_err_s)        state_nxt_s = SEARCH;
        else if (frame_bnd_s) state_nxt_s = LOCKED;
        else                  state_nxt_s = CHECK;
      end
      LOCKED: begin
        if (geo_err_s) state_nxt_s = SEARCH;
        else           state_nxt_s = LOCKED;
      end
      default: state_nxt_s = SEARCH;
    endcase
  end

  // Output decode for the sample currently held in rgb_r, using the counter
  // values that sample will own so coordinates stay aligned with pix.
  always_comb begin
    in_h_s            = (hcnt_nxt_s >= H_BP_C) && (hcnt_nxt_s < H_END_C);
    in_v_s            = (vcnt_nxt_s >= V_BP_C) && (vcnt_nxt_s < V_END_C);
    de_nxt_s          = (state_nxt_s == LOCKED) && in_h_s && in_v_s;
    x_nxt_s           = 9'd0;
    y_nxt_s           = 9'd0;
    pix_nxt_s         = 3'd0;
    if (de_nxt_s) begin
      x_nxt_s   = 9'(hcnt_nxt_s - H_BP_C);
      y_nxt_s   = 9'(vcnt_nxt_s - V_BP_C);
      pix_nxt_s = rgb_r;
    end else begin
      x_nxt_s   = 9'd0;
      y_nxt_s   = 9'd0;
      pix_nxt_s = 3'd0;
    end
    frame_start_nxt_s = de_nxt_s && (hcnt_nxt_s == H_BP_C) && (vcnt_nxt_s == V_BP_C);
    err_inc_s         = geo_err_s && (state_r != SEARCH);
    sum_pub_s         = frame_bnd_s && (state_r == LOCKED) && (state_nxt_s == LOCKED);
    acc_base_s        = frame_bnd_s ? 16'd0 : acc_r;
    if (de_nxt_s) begin
      acc_nxt_s = sig_step(acc_base_s, rgb_r);
    end else begin
      acc_nxt_s = acc_base_s;
    end
  end

  // Input sampling and geometry counters, advanced on pixel ticks only.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r      <= 1'b0;
      hs_prev_r <= 1'b0;
      vs_r      <= 1'b0;
      vs_prev_r <= 1'b0;
      rgb_r     <= 3'd0;
      hcnt_r    <= 10'd0;
      vcnt_r    <= 10'd0;
      vpend_r   <= 1'b0;
      acc_r     <= 16'd0;
    end else if (pix_en) begin
      hs_r      <= hsync;
      hs_prev_r <= hs_r;
      vs_r      <= vsync;
      vs_prev_r <= vs_r;
      rgb_r     <= rgb;
      hcnt_r    <= hcnt_nxt_s;
      vcnt_r    <= vcnt_nxt_s;
      vpend_r   <= vpend_nxt_s;
      acc_r     <= acc_nxt_s;
    end
  end

  // Output registers; pulses are cleared on every non-tick clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r           <= 9'd0;
      y_r           <= 9'd0;
      de_r          <= 1'b0;
      pix_r         <= 3'd0;
      frame_start_r <= 1'b0;
      locked_r      <= 1'b0;
      line_len_r    <= 10'd0;
      frame_lines_r <= 10'd0;
      frame_sum_r   <= 16'd0;
      sum_valid_r   <= 1'b0;
      err_cnt_r     <= 8'd0;
    end else if (pix_en) begin
      x_r           <= x_nxt_s;
      y_r           <= y_nxt_s;
      de_r          <= de_nxt_s;
      pix_r         <= pix_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      locked_r      <= (state_nxt_s == LOCKED);
      sum_valid_r   <= sum_pub_s;
      if (hfall_s)     line_len_r    <= hcnt_inc_s;
      if (frame_bnd_s) frame_lines_r <= vcnt_inc_s;
      if (sum_pub_s)   frame_sum_r   <= acc_r;
      if (err_inc_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      frame_start_r <= 1'b0;
      sum_valid_r   <= 1'b0;
    end
  end

  assign x           = x_r;
  assign y           = y_r;
  assign de          = de_r;
  assign pix         = pix_r;
  assign frame_start = frame_start_r;
  assign locked      = locked_r;
  assign line_len    = line_len_r;
  assign frame_lines = frame_lines_r;
  assign frame_sum   = frame_sum_r;
  assign sum_valid   = sum_valid_r;
  assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_crt_sync_monitor.sv
// Directed bench for crt_sync_monitor using reduced geometry (40x20 lines,
// 16x8 active) so complete frames fit comfortably in simulation.
module tb_crt_sync_monitor;

  localparam int HT  = 40;
  localparam int VT  = 20;
  localparam int HBP = 6;
  localparam int VBP = 2;
  localparam int HA  = 16;
  localparam int VA  = 8;

  logic        clk, reset, pix_en, hsync, vsync;
  logic [2:0]  rgb;
  logic [8:0]  x, y;
  logic        de, frame_start, locked, sum_valid;
  logic [2:0]  pix;
  logic [9:0]  line_len, frame_lines;
  logic [15:0] frame_sum;
  logic [7:0]  err_cnt;
  logic [68:0] all_out;

  int tests = 0;
  int fails = 0;
  int de_cnt, xmin, xmax, ymin, ymax, fs_cnt, fs_bad, sv_cnt, stray_cnt;
  int coord_bad, zero_bad;
  logic [15:0] last_sum;
  int prev_h = -100;
  int prev_v = -100;
  logic [2:0] prev_rgb = 3'd0;

  crt_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_BP(HBP), .V_BP(VBP), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x(x), .y(y), .de(de), .pix(pix), .frame_start(frame_start), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .frame_sum(frame_sum),
    .sum_valid(sum_valid), .err_cnt(err_cnt)
  );

  assign all_out = {x, y, de, pix, frame_start, locked, line_len, frame_lines,
                    frame_sum, sum_valid, err_cnt};

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [2:0] pat(input int mode, input int h, input int v);
    int k;
    case (mode)
      1:       k = (h == HBP && v == VBP) ? 1 : 0;
      2:       k = (h == HBP + HA - 1 && v == VBP + VA - 1) ? 1 : 0;
      3:       k = h * 3 + v * 5 + 1;
      default: k = 0;
    endcase
    return k[2:0];
  endfunction

  function automatic logic [15:0] sig_model(input int mode);
    logic [15:0] a;
    a = 16'd0;
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        a = {a[14:0], a[15]} ^ {13'd0, pat(mode, xx + HBP, yy + VBP)};
    return a;
  endfunction

  task automatic clear_stats();
    de_cnt = 0; fs_cnt = 0; fs_bad = 0; sv_cnt = 0; stray_cnt = 0;
    coord_bad = 0; zero_bad = 0;
    xmin = 999; xmax = -1; ymin = 999; ymax = -1;
  endtask

  // One pixel tick followed by one idle clock; observes the DUT after the tick.
  task automatic tick(input logic hs, input logic vs, input logic [2:0] c,
                      input int h, input int v);
    @(negedge clk);
    if (frame_start !== 1'b0 || sum_valid !== 1'b0) stray_cnt++;
    hsync = hs; vsync = vs; rgb = c; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    if (de === 1'b1) begin
      de_cnt++;
      if (x !== 9'(prev_h - HBP) || y !== 9'(prev_v - VBP) || pix !== prev_rgb) coord_bad++;
      if (int'(x) < xmin) xmin = int'(x);
      if (int'(x) > xmax) xmax = int'(x);
      if (int'(y) < ymin) ymin = int'(y);
      if (int'(y) > ymax) ymax = int'(y);
    end else if (de !== 1'b0 || x !== 9'd0 || y !== 9'd0 || pix !== 3'd0) begin
      zero_bad++;
    end
    if (frame_start === 1'b1) begin
      fs_cnt++;
      if (!(de === 1'b1 && x === 9'd0 && y === 9'd0)) fs_bad++;
    end
    if (sum_valid === 1'b1) begin
      sv_cnt++;
      last_sum = frame_sum;
    end
    prev_h = h; prev_v = v; prev_rgb = c;
  endtask

  task automatic gen_line(input int v, input int len, input int mode);
    for (int h = 0; h < len; h++)
      tick(h >= len - 4, v >= VT - 3, pat(mode, h, v), h, v);
  endtask

  task automatic gen_frame(input int mode);
    for (int v = 0; v < VT; v++) gen_line(v, HT, mode);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (all_out !== 69'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal_lock();
    clear_stats();
    gen_line(VT - 2, HT, 0);
    gen_line(VT - 1, HT, 0);
    gen_frame(0);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %b expected 0", locked); end
    clear_stats();
    gen_frame(3);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL lock_second: got %b expected 1", locked); end
    tests++;
    if (line_len !== 10'd40) begin fails++; $display("FAIL line_len: got %0d expected 40", line_len); end
    tests++;
    if (frame_lines !== 10'd20) begin fails++; $display("FAIL frame_lines: got %0d expected 20", frame_lines); end
    tests++;
    if (de_cnt != 128) begin fails++; $display("FAIL de_count: got %0d expected 128", de_cnt); end
    tests++;
    if (xmin != 0 || xmax != 15) begin fails++; $display("FAIL x_span: got %0d..%0d expected 0..15", xmin, xmax); end
    tests++;
    if (ymin != 0 || ymax != 7) begin fails++; $display("FAIL y_span: got %0d..%0d expected 0..7", ymin, ymax); end
    tests++;
    if (fs_cnt != 1 || fs_bad != 0) begin fails++; $display("FAIL frame_start: got %0d pulses (%0d misplaced) expected 1", fs_cnt, fs_bad); end
    tests++;
    if (coord_bad != 0) begin fails++; $display("FAIL pixel_align: got %0d bad pixels expected 0", coord_bad); end
    tests++;
    if (zero_bad != 0) begin fails++; $display("FAIL idle_zero: got %0d nonzero idle outputs expected 0", zero_bad); end
  endtask

  task automatic test_signature();
    logic [15:0] exp_hash;
    exp_hash = sig_model(3);
    clear_stats();
    gen_frame(1);
    tests++;
    if (sv_cnt != 1 || last_sum !== exp_hash) begin
      fails++; $display("FAIL sum_pattern: got %h (%0d pulses) expected %h (1 pulse)", last_sum, sv_cnt, exp_hash);
    end
    gen_frame(2);
    tests++;
    if (last_sum !== 16'h8000) begin fails++; $display("FAIL sum_first_pixel: got %h expected 8000", last_sum); end
    gen_frame(0);
    tests++;
    if (last_sum !== 16'h0001) begin fails++; $display("FAIL sum_last_pixel: got %h expected 0001", last_sum); end
    gen_frame(3);
    tests++;
    if (last_sum !== 16'h0000 || frame_sum !== 16'h0000) begin
      fails++; $display("FAIL sum_all_zero: got %h/%h expected 0000", last_sum, frame_sum);
    end
    tests++;
    if (sv_cnt != 4) begin fails++; $display("FAIL sum_valid_count: got %0d expected 4", sv_cnt); end
    tests++;
    if (stray_cnt != 0) begin fails++; $display("FAIL pulse_width: got %0d held pulses expected 0", stray_cnt); end
    tests++;
    if (coord_bad != 0 || zero_bad != 0 || fs_bad != 0) begin
      fails++; $display("FAIL sig_pixels: got %0d/%0d/%0d bad expected 0", coord_bad, zero_bad, fs_bad);
    end
  endtask

  task automatic test_bad_line();
    for (int v = 0; v < 5; v++) gen_line(v, HT, 0);
    tests++;
    if (locked !== 1'b1 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL bad_line_pre: got locked=%b err=%0d expected 1/0", locked, err_cnt);
    end
    gen_line(5, HT + 1, 0);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL bad_line_hold: got %b expected 1", locked); end
    gen_line(6, HT, 0);
    tests++;
    if (locked !== 1'b0 || err_cnt !== 8'd1 || line_len !== 10'd41) begin
      fails++; $display("FAIL bad_line_drop: got locked=%b err=%0d len=%0d expected 0/1/41", locked, err_cnt, line_len);
    end
    for (int v = 7; v < VT; v++) gen_line(v, HT, 0);
    gen_frame(0);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL bad_line_check: got %b expected 0", locked); end
    gen_frame(0);
    tests++;
    if (locked !== 1'b1 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL bad_line_relock: got locked=%b err=%0d expected 1/1", locked, err_cnt);
    end
  endtask

  task automatic test_stuck_hsync();
    for (int i = 0; i < 1100; i++) tick(1'b0, 1'b0, 3'd0, i, 0);
    tests++;
    if (locked !== 1'b0 || de !== 1'b0) begin
      fails++; $display("FAIL stuck_unlock: got locked=%b de=%b expected 0/0", locked, de);
    end
    tests++;
    if (err_cnt !== 8'd2) begin fails++; $display("FAIL stuck_err: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_midframe_reset();
    gen_frame(0);
    gen_frame(0);
    gen_frame(3);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL pre_reset_lock: got %b expected 1", locked); end
    for (int v = 0; v < 6; v++) gen_line(v, HT, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (all_out !== 69'd0) begin fails++; $display("FAIL midframe_reset: got %h expected 0", all_out); end
    reset = 1'b0;
    for (int v = 6; v < VT; v++) gen_line(v, HT, 3);
    gen_frame(0);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL reset_relock_early: got %b expected 0", locked); end
    clear_stats();
    gen_frame(3);
    tests++;
    if (locked !== 1'b1 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_relock: got locked=%b err=%0d expected 1/0", locked, err_cnt);
    end
    tests++;
    if (de_cnt != 128 || coord_bad != 0 || line_len !== 10'd40 || frame_lines !== 10'd20) begin
      fails++; $display("FAIL reset_geometry: got de=%0d bad=%0d len=%0d lines=%0d expected 128/0/40/20",
                        de_cnt, coord_bad, line_len, frame_lines);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = 3'd0;
    last_sum = 16'd0;
    clear_stats();
    test_reset();
    test_nominal_lock();
    test_signature();
    test_bad_line();
    test_stuck_hsync();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
